dense_argmax: RTL

- Classifier stage directly downstream of the dense layer.
- Snapshots the dense layer's NC+1 signed class scores when the dense stage signals completion.
- Scans the snapshot serially, one class per cycle, to find the highest score.
- Presents the winning class index and its score with a sticky valid flag and a one-cycle done pulse, for the board output logic (LEDs / UART).

---
 rtl/cnn_pkg.sv | 8 +
 rtl/argmax_cmp.sv | 18 +
 rtl/dense_argmax.sv | 100 ++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and types shared by the dense layer and its argmax stage
package cnn_pkg;
   localparam int NC      = 9;
   localparam int SCORE_W = 8;
   localparam int IDX_W   = 4;
   typedef logic signed [SCORE_W-1:0] score_t;
   typedef enum logic [1:0] {IDLE, SCAN, POST} state_t;
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: signed strict-greater compare-and-select of a candidate against the running best
module argmax_cmp #(
   parameter int SCORE_W = cnn_pkg::SCORE_W,
   parameter int IDX_W   = cnn_pkg::IDX_W
) (
   input  logic signed [SCORE_W-1:0] best,
   input  logic        [IDX_W-1:0]   best_idx,
   input  logic signed [SCORE_W-1:0] cand,
   input  logic        [IDX_W-1:0]   cand_idx,
   output logic signed [SCORE_W-1:0] sel_score,
   output logic        [IDX_W-1:0]   sel_idx
);
   // Strict compare keeps the earlier (lower) index on ties
   logic w_gt;
   assign w_gt      = cand > best;
   assign sel_score = w_gt ? cand : best;
   assign sel_idx   = w_gt ? cand_idx : best_idx;
endmodule

// File: rtl/dense_argmax.sv
// dense_argmax: snapshots the dense layer's class scores on a start edge and
// scans them one per cycle to post the winning class index and score.
module dense_argmax #(
   parameter int NC      = cnn_pkg::NC,
   parameter int SCORE_W = cnn_pkg::SCORE_W,
   parameter int IDX_W   = cnn_pkg::IDX_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [SCORE_W-1:0] scores [0:NC],
   input  logic                      clear,
   output logic                      busy,
   output logic                      valid,
   output logic                      done,
   output logic        [IDX_W-1:0]   class_idx,
   output logic signed [SCORE_W-1:0] max_score
);
   import cnn_pkg::*;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NC);

   state_t                    r_state, w_next;
   logic                      r_start_q, r_busy, r_valid, r_done;
   logic signed [SCORE_W-1:0] r_snap [0:NC];
   logic signed [SCORE_W-1:0] r_best, r_max, w_best;
   logic        [IDX_W-1:0]   r_best_idx, r_cnt, r_idx, w_best_idx;
   logic                      w_start_edge;

   assign w_start_edge = start & ~r_start_q;

   argmax_cmp #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_cmp (
      .best     (r_best),
      .best_idx (r_best_idx),
      .cand     (r_snap[r_cnt]),
      .cand_idx (r_cnt),
      .sel_score(w_best),
      .sel_idx  (w_best_idx)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_start_edge ? SCAN : IDLE;
         SCAN:    w_next = (r_cnt == LAST) ? POST : SCAN;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_start_q  <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_max      <= '0;
         for (int i = 0; i <= NC; i++) r_snap[i] <= '0;
      end else begin
         r_start_q <= start;
         r_done    <= 1'b0;
         if (clear) r_valid <= 1'b0;
         case (r_state)
            IDLE: if (w_start_edge) begin
               for (int i = 0; i <= NC; i++) r_snap[i] <= scores[i];
               r_best     <= scores[0];
               r_best_idx <= '0;
               r_cnt      <= IDX_W'(1);
               r_busy     <= 1'b1;
               r_valid    <= 1'b0;
            end
            SCAN: begin
               r_best     <= w_best;
               r_best_idx <= w_best_idx;
               if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
            end
            default: begin
               // Posting wins over a simultaneous clear
               r_idx   <= r_best_idx;
               r_max   <= r_best;
               r_valid <= 1'b1;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign valid     = r_valid;
   assign done      = r_done;
   assign class_idx = r_idx;
   assign max_score = r_max;
endmodule
